// File: rtl/demod_sched_pkg.sv
// rtl/demod_sched_pkg.sv - shared types, default constants and helpers for the demod segment scheduler
package demod_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } sched_state_e;

  localparam int NUM_REQ_D  = 4;
  localparam int DATA_W_D   = 32;
  localparam int PIPE_LAT_D = 3;
  localparam int MAX_REQ    = 8;

  // One-hot vector wide enough for the largest supported requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot = 8'(1) << idx;
  endfunction

endpackage

// File: rtl/demod_segment_scheduler_rr_pick.sv
// rtl/demod_segment_scheduler_rr_pick.sv - combinational round-robin priority picker
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int         pos;
  logic [IDX_W-1:0] pos_w;

  // Walk from rr_ptr upward with wrap; the first set bit seen wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    pos_w = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_w = IDX_W'(pos);
      if (!any_o && req_i[pos_w]) begin
        any_o = 1'b1;
        idx_o = pos_w;
      end
    end
  end

endmodule

// File: rtl/demod_segment_scheduler.sv
// rtl/demod_segment_scheduler.sv - round-robin owner of the shared demodulation segment; watchdog under DEMOD_SCHED_TIMEOUT_EN
module demod_segment_scheduler
  import demod_sched_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_D,
  parameter int DATA_W      = DATA_W_D,
  parameter int PIPE_LAT    = PIPE_LAT_D,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      pipe_start,
  output logic [DATA_W-1:0]         pipe_data,
  input  logic                      pipe_valid,
  output logic                      busy,
  output logic [NUM_REQ-1:0]        err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject unsupported configurations at elaboration time.
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || PIPE_LAT < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("demod_segment_scheduler: unsupported parameter set");
  end

  sched_state_e        state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                pipe_start_q, pipe_start_d;
  logic [DATA_W-1:0]   pipe_data_q, pipe_data_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [MAX_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]    owner_next;
  logic [DATA_W-1:0]   words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = req_data[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign pick_oh    = onehot(3'(pick_idx));
  assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef DEMOD_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  assign err = err_q;
`else
  assign err = '0;
`endif

  // State and registered outputs; reset aborts any transaction without a done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      pipe_start_q <= 1'b0;
      pipe_data_q  <= '0;
`ifdef DEMOD_SCHED_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      pipe_start_q <= pipe_start_d;
      pipe_data_q  <= pipe_data_d;
`ifdef DEMOD_SCHED_TIMEOUT_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

  // Next-state: grant from IDLE, wait for valid in RUN, one clearing cycle in GAP.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    done_d       = '0;
    pipe_start_d = pipe_start_q;
    pipe_data_d  = pipe_data_q;
`ifdef DEMOD_SCHED_TIMEOUT_EN
    wd_d         = wd_q;
    err_d        = '0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d      = pick_idx;
          grant_d      = pick_oh[NUM_REQ-1:0];
          pipe_data_d  = words[pick_idx];
          pipe_start_d = 1'b1;
          state_d      = RUN;
`ifdef DEMOD_SCHED_TIMEOUT_EN
          wd_d         = '0;
`endif
        end
      end
      RUN: begin
        if (pipe_valid) begin
          done_d       = grant_q;
          grant_d      = '0;
          pipe_start_d = 1'b0;
          rr_ptr_d     = owner_next;
          state_d      = GAP;
        end
`ifdef DEMOD_SCHED_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          err_d        = grant_q;
          grant_d      = '0;
          pipe_start_d = 1'b0;
          rr_ptr_d     = owner_next;
          state_d      = GAP;
        end else begin
          wd_d         = wd_q + WD_W'(1);
        end
`endif
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign pipe_start = pipe_start_q;
  assign pipe_data  = pipe_data_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_demod_segment_scheduler.sv
// tb/tb_demod_segment_scheduler.sv - directed self-checking bench for the demod segment scheduler
module tb_demod_segment_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PL = 3;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    grant, done, err;
  logic            pipe_start, busy, pipe_valid;
  logic [DW-1:0]   pipe_data;

  int checks = 0;
  int errors = 0;

  // Pipe model: valid once start has been high PL cycles; stuck forces valid low, extra forces it high.
  logic [3:0] pcnt = '0;
  logic       stuck = 1'b0;
  logic       extra = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!pipe_start) pcnt <= '0;
    else if (pcnt != 4'hF) pcnt <= pcnt + 4'd1;
  end

  assign pipe_valid = (pipe_start && (pcnt >= 4'(PL - 1)) && !stuck) || extra;

  demod_segment_scheduler #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .PIPE_LAT    (PL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .done       (done),
    .pipe_start (pipe_start),
    .pipe_data  (pipe_data),
    .pipe_valid (pipe_valid),
    .busy       (busy),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, done, err, pipe_start, busy} !== {4'b0, 4'b0, 4'b0, 1'b0, 1'b0} || pipe_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: grant=%b done=%b err=%b start=%b busy=%b data=%h, want all 0",
               grant, done, err, pipe_start, busy, pipe_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    req_data[0*DW +: DW] = 32'hA5A5_0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) req = 4'b0000;
      checks++;
      if ({grant, done, pipe_start, busy} !== {4'b0001, 4'b0000, 1'b1, 1'b1} || pipe_data !== 32'hA5A5_0001) begin
        errors++;
        $display("FAIL single_run c%0d: grant=%b done=%b start=%b busy=%b data=%h, want 0001 0000 1 1 a5a50001",
                 c, grant, done, pipe_start, busy, pipe_data);
      end
    end
    tick();
    checks++;
    if ({grant, done, pipe_start, busy} !== {4'b0000, 4'b0001, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_done: grant=%b done=%b start=%b busy=%b, want 0000 0001 0 1", grant, done, pipe_start, busy);
    end
    tick();
    checks++;
    if ({grant, done, pipe_start, busy} !== {4'b0000, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_idle: grant=%b done=%b start=%b busy=%b, want 0000 0000 0 0", grant, done, pipe_start, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
    for (int t = 0; t < 5; t++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if (grant !== exp_g[t] || done !== 4'b0 || pipe_start !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant t%0d c%0d: grant=%b done=%b start=%b, want %b 0000 1", t, c, grant, done, pipe_start, exp_g[t]);
        end
      end
      tick();
      checks++;
      if (done !== exp_g[t] || grant !== 4'b0) begin
        errors++;
        $display("FAIL rr_done t%0d: done=%b grant=%b, want %b 0000", t, done, grant, exp_g[t]);
      end
      tick();
      checks++;
      if (done !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap t%0d: done=%b grant=%b busy=%b, want 0000 0000 0", t, done, grant, busy);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_skip_idle();
    logic [N-1:0] exp_g [3];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
    do_reset();
    req = 4'b1010;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 5; c++) begin
        tick();
        checks++;
        if (c < 3 && grant !== exp_g[t]) begin
          errors++;
          $display("FAIL skip_grant t%0d c%0d: grant=%b, want %b", t, c, grant, exp_g[t]);
        end else if (c >= 3 && grant !== 4'b0) begin
          errors++;
          $display("FAIL skip_free t%0d c%0d: grant=%b, want 0000", t, c, grant);
        end
        if (c == 3) begin
          checks++;
          if (done !== exp_g[t]) begin
            errors++;
            $display("FAIL skip_done t%0d: done=%b, want %b", t, done, exp_g[t]);
          end
        end
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_drop_change();
    do_reset();
    req = 4'b0100;
    req_data[2*DW +: DW] = 32'h1111_2222;
    tick();
    checks++;
    if (grant !== 4'b0100 || pipe_data !== 32'h1111_2222) begin
      errors++;
      $display("FAIL drop_grant: grant=%b data=%h, want 0100 11112222", grant, pipe_data);
    end
    req = 4'b0000;
    req_data[2*DW +: DW] = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0100 || pipe_data !== 32'h1111_2222) begin
        errors++;
        $display("FAIL drop_hold c%0d: grant=%b data=%h, want 0100 11112222", c, grant, pipe_data);
      end
    end
    tick();
    checks++;
    if (done !== 4'b0100) begin
      errors++;
      $display("FAIL drop_done: done=%b, want 0100", done);
    end
    tick();
    tick();
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_regrant: grant=%b busy=%b, want 0000 0", grant, busy);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    reset = 1'b1;
    req = 4'b0001;
    req_data[0*DW +: DW] = 32'h0000_00A0;
    tick();
    reset = 1'b0;
    checks++;
    if ({grant, done, pipe_start, busy} !== {4'b0000, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mreset_abort: grant=%b done=%b start=%b busy=%b, want 0000 0000 0 0", grant, done, pipe_start, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || done !== 4'b0 || pipe_data !== 32'h0000_00A0) begin
      errors++;
      $display("FAIL mreset_regrant: grant=%b done=%b data=%h, want 0001 0000 000000a0", grant, done, pipe_data);
    end
    req = 4'b0000;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_valid_ignored();
    do_reset();
    extra = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 4'b0) begin
      errors++;
      $display("FAIL valid_idle: busy=%b done=%b, want 0 0000", busy, done);
    end
    extra = 1'b0;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    tick();
    tick();
    tick();
    extra = 1'b1;
    tick();
    checks++;
    if (done !== 4'b0 || busy !== 1'b0 || err !== 4'b0) begin
      errors++;
      $display("FAIL valid_gap: done=%b busy=%b err=%b, want 0000 0 0000", done, busy, err);
    end
    extra = 1'b0;
    tick();
  endtask

`ifdef DEMOD_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    stuck = 1'b1;
    req = 4'b0011;
    tick();
    for (int c = 0; c < TO; c++) begin
      checks++;
      if (grant !== 4'b0001 || err !== 4'b0 || done !== 4'b0) begin
        errors++;
        $display("FAIL to_wait c%0d: grant=%b err=%b done=%b, want 0001 0000 0000", c, grant, err, done);
      end
      tick();
    end
    checks++;
    if (err !== 4'b0001 || done !== 4'b0 || grant !== 4'b0 || pipe_start !== 1'b0) begin
      errors++;
      $display("FAIL to_err: err=%b done=%b grant=%b start=%b, want 0001 0000 0000 0", err, done, grant, pipe_start);
    end
    tick();
    checks++;
    if (err !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_gap: err=%b busy=%b, want 0000 0", err, busy);
    end
    stuck = 1'b0;
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL to_next: grant=%b, want 0010", grant);
    end
    req = 4'b0000;
    for (int c = 0; c < 6; c++) tick();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    stuck = 1'b1;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || err !== 4'b0 || done !== 4'b0) begin
        errors++;
        $display("FAIL nto_wait c%0d: grant=%b err=%b done=%b, want 0001 0000 0000", c, grant, err, done);
      end
    end
    stuck = 1'b0;
    tick();
    checks++;
    if (done !== 4'b0001 || err !== 4'b0) begin
      errors++;
      $display("FAIL nto_done: done=%b err=%b, want 0001 0000", done, err);
    end
    tick();
    tick();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_skip_idle();
    test_drop_change();
    test_mid_reset();
    test_valid_ignored();
`ifdef DEMOD_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demod_segment_scheduler.md
Name: demod_segment_scheduler

Overview:
- Round-robin scheduler that shares one `Demodulation_segment_5_with_control` pipe among NUM_REQ requesters.
- Latches the winning requester's 32-bit word and drives the pipe's `start` and `input_bit`.
- Waits for the pipe's `valid` and returns a one-cycle `done` to the owner, then frees the pipe.
- Sits between the symbol sources and the shared demodulation segment; the segment outputs fan out directly from the pipe, qualified by `done`.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 32: width of the input word.
- PIPE_LAT, 3: cycles with `start` high until the pipe raises `valid`.
- TIMEOUT_CYC, 16: watchdog limit in RUN (only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester level request.
- req_data  in  NUM_REQ*DATA_W  requester i's word at bits [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot owner of the pipe.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- pipe_start  out  1  drives the pipe `start`.
- pipe_data  out  DATA_W  drives the pipe `input_bit`.
- pipe_valid  in  1  from the pipe `valid`.
- busy  out  1  high whenever state != IDLE.
- err  out  NUM_REQ  one-cycle timeout pulse (only with the optional feature; tied 0 otherwise).

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - grant, done, err = 0.
  - pipe_start=0, pipe_data=0, busy=0.
  - Reset mid-transaction aborts it; no done is issued.
- IDLE:
  - If req != 0, pick the first set bit searching from rr_ptr upward with wrap.
  - At that edge: register grant=onehot(idx); latch pipe_data=req_data[idx]; pipe_start=1; go to RUN.
  - Otherwise all outputs stay idle.
- RUN:
  - pipe_start held 1; pipe_data and grant held constant.
  - When pipe_valid is sampled 1: register done[idx]=1, grant=0, pipe_start=0; set rr_ptr=(idx+1) mod NUM_REQ; go to GAP.
- GAP:
  - Exactly one cycle with pipe_start=0 so the pipe counter clears. done returns to 0. Go to IDLE.
- Latency (PIPE_LAT=3):
  - req sampled at edge E; grant and pipe_start high after E.
  - pipe_valid sampled at E+3; done high during the cycle after E+3.
  - Earliest next grant after edge E+5.
  - Back-to-back period is PIPE_LAT+2 = 5 cycles.
- Requests:
  - Dropping req during RUN is ignored; the transaction completes and done still pulses.
  - req_data changes after grant are ignored because the word is latched.
  - Requests arriving during RUN or GAP wait; req is level, with no queueing beyond that.
- Fairness: the owner moves to lowest priority after completion, so no requester waits more than NUM_REQ-1 transactions.
- pipe_valid high while in IDLE or GAP is ignored.

Optional Feature:
- Macro: DEMOD_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC without pipe_valid: pulse err[idx] for one cycle, no done, pipe_start=0, grant=0, rr_ptr advances, go to GAP.
- Undefined:
  - No counter; err is tied 0; RUN waits indefinitely.

Decomposition:
- Package demod_sched_pkg holds:
  - the state enum {IDLE, RUN, GAP}, 2 bits;
  - default constants NUM_REQ_D=4, DATA_W_D=32, PIPE_LAT_D=3;
  - a function onehot(idx).
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req and rr_ptr.
  - Outputs: idx and any.
  - Reusable by other shared-segment schedulers.

Test Plan:
- Single request: req=4'b0001, req_data[0]=32'hA5A5_0001 with the real pipe attached.
  - grant=0001 and pipe_data=A5A5_0001 for 3 cycles; done=0001 for 1 cycle; busy returns 0 two cycles later.
- Round-robin order: req=4'b1111 held.
  - Grants 0001→0010→0100→1000→0001, spaced 5 cycles; each done matches the preceding grant.
- Skip idle requesters: req=4'b1010.
  - Grants 0010, 1000, 0010; no grant ever to idle bits.
- Drop and change inputs mid-RUN: req[2] drops and req_data[2] changes 1 cycle after grant.
  - pipe_data keeps the latched value; done[2] still pulses.
- Reset mid-transaction: reset for 1 cycle in the second RUN cycle.
  - Next cycle grant=0, pipe_start=0, busy=0, no done; the next req=0001 is granted (rr_ptr=0).
- Timeout (DEMOD_SCHED_TIMEOUT_EN, pipe_valid stuck 0, TIMEOUT_CYC=16):
  - err[idx] pulses after 16 RUN cycles; no done; the next requester is granted after the GAP cycle.
